// File: rtl/sd_rx_drain_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : sd_rx_drain_ctrl
// Brief    : Drains the SD receive FIFO into memory, one req/ack write per word.
// Revision : 1.0 - initial release
// ============================================================================
module sd_rx_drain_ctrl #(
    parameter int AW = 32,
    parameter int CW = 16
) (
    input  logic          rclk,
    input  logic          rst,
    input  logic          start,
    input  logic          abort,
    input  logic [AW-1:0] base_addr,
    input  logic [CW-1:0] word_cnt,
    input  logic          fifo_empty,
    input  logic          fifo_full,
    input  logic [31:0]   fifo_q,
    output logic          fifo_rd,
    output logic          m_req,
    output logic [AW-1:0] m_addr,
    output logic [31:0]   m_data,
    input  logic          m_ack,
    output logic          busy,
    output logic          done,
    output logic          overrun,
    output logic [CW-1:0] words_left
);

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_FETCH = 3'd1;
    localparam logic [2:0] c_LATCH = 3'd2;
    localparam logic [2:0] c_WRITE = 3'd3;
    localparam logic [2:0] c_DONE  = 3'd4;

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [AW-1:0] r_addr;
    logic [CW-1:0] r_left;
    logic [31:0]   r_data;
    logic          r_overrun;
    logic          w_load;
    logic          w_wr_accept;

    assign w_load      = (r_state == c_IDLE) && start;
    assign w_wr_accept = (r_state == c_WRITE) && m_ack;

    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (start) begin
                    w_next = (word_cnt == '0) ? c_DONE : c_FETCH;
                end
            end
            c_FETCH: begin
                if (!fifo_empty) begin
                    w_next = c_LATCH;
                end
            end
            c_LATCH: w_next = c_WRITE;
            c_WRITE: begin
                if (m_ack) begin
                    w_next = (r_left == CW'(1)) ? c_DONE : c_FETCH;
                end
            end
            c_DONE:  w_next = c_IDLE;
            default: w_next = c_IDLE;
        endcase
        // Abort wins over every transition out of a busy state.
        if (abort && (r_state != c_IDLE)) begin
            w_next = c_IDLE;
        end
    end

    always_comb begin
        fifo_rd = (r_state == c_FETCH) && !fifo_empty;
        m_req   = (r_state == c_WRITE);
        busy    = (r_state != c_IDLE);
        done    = (r_state == c_DONE);
    end

    // An ack coinciding with abort still advances addr/left.
    always_ff @(posedge rclk or posedge rst) begin
        if (rst) begin
            r_addr    <= '0;
            r_left    <= '0;
            r_data    <= '0;
            r_overrun <= 1'b0;
        end else begin
            if (w_load) begin
                r_addr    <= {base_addr[AW-1:2], 2'b00};
                r_left    <= word_cnt;
                r_overrun <= 1'b0;
            end else begin
                if ((r_state != c_IDLE) && fifo_full) begin
                    r_overrun <= 1'b1;
                end
                if (r_state == c_LATCH) begin
                    r_data <= fifo_q;
                end
                if (w_wr_accept) begin
                    r_addr <= r_addr + AW'(4);
                    r_left <= r_left - CW'(1);
                end
            end
        end
    end

    assign m_addr     = r_addr;
    assign m_data     = r_data;
    assign overrun    = r_overrun;
    assign words_left = r_left;

endmodule
`default_nettype wire

// File: tb/tb_sd_rx_drain_ctrl.sv
`timescale 1ns/1ps
`default_nettype none
// ============================================================================
// Module   : tb_sd_rx_drain_ctrl
// Brief    : Self-checking bench: vector table, random transfers, corner cases.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sd_rx_drain_ctrl;

    localparam int AW = 32;
    localparam int CW = 16;

    logic          rclk = 1'b0;
    logic          rst, start, abort, fifo_full, m_ack;
    logic [AW-1:0] base_addr;
    logic [CW-1:0] word_cnt;
    logic          fifo_empty;
    logic [31:0]   fifo_q = '0;
    logic          fifo_rd, m_req, busy, done, overrun;
    logic [AW-1:0] m_addr;
    logic [31:0]   m_data;
    logic [CW-1:0] words_left;

    logic          hold_empty = 1'b0;
    logic          flush = 1'b0;
    logic [31:0]   mem [0:255];
    logic [7:0]    wp = '0;
    logic [7:0]    rp = '0;
    logic [31:0]   exp_data [0:255];

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic [31:0] base;
        int          cnt;
        int          ack_wait;
        int          gap;
        int          full_at;
        int          exp_lat;
        logic [31:0] exp_end;
    } vec_t;
    vec_t vecs [6];

    sd_rx_drain_ctrl #(.AW(AW), .CW(CW)) dut (
        .rclk(rclk), .rst(rst), .start(start), .abort(abort),
        .base_addr(base_addr), .word_cnt(word_cnt),
        .fifo_empty(fifo_empty), .fifo_full(fifo_full), .fifo_q(fifo_q),
        .fifo_rd(fifo_rd), .m_req(m_req), .m_addr(m_addr), .m_data(m_data),
        .m_ack(m_ack), .busy(busy), .done(done), .overrun(overrun),
        .words_left(words_left)
    );

    always #5 rclk = ~rclk;

    // FIFO read side: q is valid the cycle after rd.
    assign fifo_empty = (wp == rp) || hold_empty;
    always @(posedge rclk) begin
        if (flush) begin
            rp <= wp;
        end else if (fifo_rd) begin
            fifo_q <= mem[rp];
            rp     <= rp + 8'd1;
        end
    end

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic cycle();
        @(posedge rclk);
        #1;
    endtask

    task automatic flush_fifo();
        hold_empty = 1'b0;
        flush = 1'b1;
        cycle();
        flush = 1'b0;
    endtask

    task automatic push_words(input int n);
        for (int i = 0; i < n; i++) begin
            exp_data[i] = $urandom;
            mem[wp] = exp_data[i];
            wp = wp + 8'd1;
        end
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, "_fifo_rd"}, fifo_rd, 0);
        chk({tag, "_m_req"}, m_req, 0);
        chk({tag, "_m_addr"}, m_addr, 0);
        chk({tag, "_m_data"}, m_data, 0);
        chk({tag, "_busy"}, busy, 0);
        chk({tag, "_done"}, done, 0);
        chk({tag, "_overrun"}, overrun, 0);
        chk({tag, "_words_left"}, words_left, 0);
    endtask

    // One complete transfer; expectations come from word order, address
    // arithmetic and the bench's own count of acks/reads.
    task automatic run_xfer(input logic [31:0] base, input int cnt, input int ack_wait,
                            input int gap, input int full_at, input bit rnd,
                            input int exp_lat, input logic [31:0] exp_end);
        logic [31:0] a0;
        logic [31:0] exp_addr;
        int lat, wr, rd, req, waited, gap_left;
        bit fin, exp_ovr;
        a0 = {base[31:2], 2'b00};
        push_words(cnt);
        base_addr = base;
        word_cnt  = cnt[CW-1:0];
        start     = 1'b1;
        cycle();
        start = 1'b0;
        lat = 1; wr = 0; rd = 0; req = 0; waited = 0; gap_left = 0;
        fin = 1'b0; exp_ovr = 1'b0;
        for (int c = 0; c < 400 && !fin; c++) begin
            hold_empty = rnd ? ($urandom_range(2) == 0) : (gap_left > 0);
            if (gap_left > 0) gap_left--;
            fifo_full = rnd ? ($urandom_range(15) == 0) : (c == full_at);
            #1;
            chk("words_left", words_left, 64'(cnt - wr));
            chk("overrun", overrun, exp_ovr);
            if (fifo_rd) rd++;
            if (fifo_full) exp_ovr = 1'b1;
            if (done) begin
                fin = 1'b1;
                m_ack = 1'b0;
            end else begin
                chk("busy", busy, 1);
                if (m_req) begin
                    req++;
                    exp_addr = a0 + 32'(4 * wr);
                    chk("m_addr", m_addr, exp_addr);
                    chk("m_data", m_data, exp_data[wr]);
                    if (rnd) m_ack = 1'($urandom_range(1));
                    else     m_ack = (wr == 0 && waited < ack_wait) ? 1'b0 : 1'b1;
                    if (!m_ack) begin
                        waited++;
                    end else begin
                        wr++;
                        if (wr == 1) gap_left = gap;
                    end
                end else begin
                    m_ack = rnd ? 1'($urandom_range(1)) : 1'b0;
                end
                cycle();
                lat++;
            end
        end
        if (!fin) begin
            checks++;
            errors++;
            $display("FAIL done_timeout: got no done expected done within 400 cycles");
        end
        cycle();
        fifo_full = 1'b0; hold_empty = 1'b0; m_ack = 1'b0;
        chk("post_busy", busy, 0);
        chk("post_done", done, 0);
        chk("post_overrun", overrun, exp_ovr);
        chk("post_addr", m_addr, exp_end);
        chk("post_words_left", words_left, 0);
        chk("read_count", rd, cnt);
        chk("write_count", wr, cnt);
        if (!rnd) chk("req_cycles", req, cnt + ack_wait);
        if (exp_lat >= 0) chk("latency", lat, exp_lat);
    endtask

    initial begin
        int wr;
        bit aborted;
        logic [31:0] rb;
        int rc;

        vecs[0] = '{32'h0000_1003, 3, 0, 0, -1, 10, 32'h0000_100C};
        vecs[1] = '{32'h0000_2000, 1, 4, 0, -1,  8, 32'h0000_2004};
        vecs[2] = '{32'h0000_3000, 3, 0, 6, -1, 16, 32'h0000_300C};
        vecs[3] = '{32'h0000_0010, 0, 0, 0, -1,  1, 32'h0000_0010};
        vecs[4] = '{32'hFFFF_FFFE, 2, 0, 0,  2,  7, 32'h0000_0004};
        vecs[5] = '{32'h0000_0040, 5, 2, 0, -1, 18, 32'h0000_0054};

        rst = 1'b1; start = 1'b0; abort = 1'b0; fifo_full = 1'b0; m_ack = 1'b0;
        base_addr = '0; word_cnt = '0;
        cycle();
        cycle();
        check_all_zero("reset");
        rst = 1'b0;
        cycle();

        for (int i = 0; i < 6; i++) begin
            flush_fifo();
            run_xfer(vecs[i].base, vecs[i].cnt, vecs[i].ack_wait, vecs[i].gap,
                     vecs[i].full_at, 1'b0, vecs[i].exp_lat, vecs[i].exp_end);
        end

        // Abort during the write of word 1 of 4, ack withheld.
        flush_fifo();
        push_words(4);
        base_addr = 32'h500; word_cnt = 16'd4; start = 1'b1;
        cycle();
        start = 1'b0; m_ack = 1'b1; wr = 0; aborted = 1'b0;
        for (int c = 0; c < 50 && !aborted; c++) begin
            if (m_req && wr == 1) begin
                m_ack = 1'b0; abort = 1'b1;
                cycle();
                abort = 1'b0; aborted = 1'b1;
            end else begin
                if (m_req) wr++;
                cycle();
            end
        end
        chk("abort_reached", aborted, 1);
        chk("abort_busy", busy, 0);
        chk("abort_m_req", m_req, 0);
        chk("abort_done", done, 0);
        chk("abort_words_left", words_left, 3);
        chk("abort_addr", m_addr, 32'h504);
        cycle();
        chk("abort_no_done", done, 0);
        flush_fifo();
        run_xfer(32'h600, 2, 0, 0, -1, 1'b0, 7, 32'h608);

        // Async reset mid-transfer with overrun already set.
        flush_fifo();
        push_words(4);
        base_addr = 32'h700; word_cnt = 16'd4; start = 1'b1;
        cycle();
        start = 1'b0; m_ack = 1'b1; fifo_full = 1'b1;
        cycle();
        fifo_full = 1'b0;
        cycle();
        cycle();
        chk("pre_rst_overrun", overrun, 1);
        chk("pre_rst_busy", busy, 1);
        #2 rst = 1'b1;
        #1 check_all_zero("async_rst");
        cycle();
        chk("rst_hold_done", done, 0);
        #3 rst = 1'b0;
        m_ack = 1'b0;
        cycle();
        flush_fifo();

        // Random transfers against the reference model.
        for (int t = 0; t < 20; t++) begin
            rb = $urandom;
            rc = int'($urandom_range(8, 1));
            flush_fifo();
            run_xfer(rb, rc, 0, 0, -1, 1'b1, -1, {rb[31:2], 2'b00} + 32'(4 * rc));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

endmodule
`default_nettype wire

// File: doc/sd_rx_drain_ctrl.md
# sd_rx_drain_ctrl

Single-clock controller that drains the SD receive FIFO into system memory. On a start command it reads a programmed number of 32-bit words from the read side of `sd_rx_fifo`, one at a time, and issues one memory write per word over a req/ack master port at incrementing word addresses. It reports completion, supports abort, and flags FIFO overrun. It sits in the `rclk` domain between the receive FIFO and the host bus master.

## Interface
- `AW`, 32: memory address width.
- `CW`, 16: word-count width.

- `rclk`  in  1  clock, the FIFO read-side clock.
- `rst`  in  1  reset; one clock, asynchronous, active-high.
- `start`  in  1  command pulse; sampled only in IDLE.
- `abort`  in  1  cancels the transfer in any non-IDLE state.
- `base_addr`  in  AW  start byte address; bits [1:0] forced to 0 on load.
- `word_cnt`  in  CW  number of 32-bit words; 0 means immediate done.
- `fifo_empty`  in  1  FIFO `empty`.
- `fifo_full`  in  1  FIFO `full`.
- `fifo_q`  in  32  FIFO `q`; valid the cycle after `fifo_rd`.
- `fifo_rd`  out  1  FIFO `rd` strobe.
- `m_req`  out  1  write request; held until acked.
- `m_addr`  out  AW  write byte address.
- `m_data`  out  32  write data.
- `m_ack`  in  1  write accepted at this edge.
- `busy`  out  1  state != IDLE.
- `done`  out  1  one-cycle completion pulse.
- `overrun`  out  1  sticky; FIFO was full while busy.
- `words_left`  out  CW  remaining words.

## Operation
- States: IDLE, FETCH, LATCH, WRITE, DONE. Registers: state, addr, left, data, overrun.
- IDLE:
  - On `start`: load addr = {base_addr[AW-1:2],2'b00}, left = word_cnt, and clear overrun.
  - Next state is DONE if word_cnt == 0, else FETCH.
- FETCH: `fifo_rd` = (state==FETCH) & !fifo_empty, combinational. When the read fires, go to LATCH; otherwise stay in FETCH.
- LATCH: capture `fifo_q` into data, then go to WRITE.
- WRITE:
  - `m_req`=1, with `m_addr`=addr and `m_data`=data held stable.
  - On `m_ack`: addr += 4 (wraps modulo 2^AW) and left -= 1. Next state is DONE if left was 1, else FETCH.
  - Without `m_ack`: hold in WRITE.
- DONE: `done`=1 for exactly one cycle, then go to IDLE.
- `start` outside IDLE is ignored. `words_left` = left.
- Abort (non-IDLE states):
  - Next state is IDLE and no `done` pulse is produced.
  - A FETCH read firing in the same cycle still pops the FIFO; that word is discarded.
  - An `m_ack` in the same cycle as abort still updates addr/left.
- Overrun: set at any edge where busy & fifo_full. Cleared only by reset or an accepted `start`.
- `m_req`, `busy` and `done` are functions of the registered state only. `fifo_rd` is the only output that depends combinationally on an input.

## Timing
- Reset values:
  - State = IDLE.
  - All outputs 0: `fifo_rd`, `m_req`, `m_addr`, `m_data`, `busy`, `done`, `overrun`, `words_left`.
  - Reset asserted mid-transfer returns to IDLE immediately, with no `done` pulse.
- Start latency: `start` sampled at edge k gives busy=1 and FETCH from k+1.
- Per word, with a non-empty FIFO and same-cycle ack:
  - FETCH (`fifo_rd`=1), then LATCH, then WRITE (`m_req`=1), then the next FETCH.
  - This gives 3 cycles per word.
- Each extra `m_ack` wait cycle adds one cycle.
- Each cycle with `fifo_empty`=1 in FETCH adds one cycle.
- `done` is asserted in the cycle after the last ack. busy drops one cycle after `done`.
- `word_cnt`=0: `start` at edge k, then DONE in cycle k+1, then IDLE at k+2.
- Exactly one `fifo_rd` and exactly one acked write occur per word.

## Test plan
- Reset, then `start` with base_addr=0x1003 and word_cnt=3 against a prefilled FIFO holding A0,A1,A2, with ack always high. Required: writes (0x1000,A0), (0x1004,A1), (0x1008,A2), 3 cycles apart, one `done` pulse, and `words_left` ending at 0.
- `m_ack` delayed 4 cycles on word 0. Required: `m_req`, `m_addr` and `m_data` stay stable for 5 cycles, with no extra `fifo_rd`.
- FIFO empty for 6 cycles mid-transfer. Required: the controller stays in FETCH with `fifo_rd`=0, then resumes with correct data order.
- `start` with word_cnt=0. Required: `done` one cycle after start, and zero `fifo_rd` and zero `m_req`.
- `abort` during WRITE of word 1 of 4 with no ack. Required: IDLE the next cycle, `m_req`=0, no `done`, `words_left`=3. A new start then works cleanly.
- Hold `fifo_full`=1 for one cycle while busy. Required: `overrun` goes to 1 and stays 1 after `done`, and is cleared by the next `start`. Async `rst` mid-transfer clears all outputs.
